pipe_skid_reg: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake and a one-entry skid buffer, replacing bare enabled registers between MIPS pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It holds up to two words, decouples upstream stall timing from downstream back-pressure so `in_ready` is a pure register output, and supports a synchronous flush that inserts a bubble. One instance per pipeline boundary; control fields and data share one `in_data` word.

---
 rtl/pipe_skid_reg.sv | 102 ++++++++++
 tb/tb_pipe_skid_reg.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake and a one-entry skid buffer.
// All outputs are register-driven; flush empties the stage and leaves a bubble behind.
module pipe_skid_reg #(
    parameter int unsigned          DATA_BITS    = 32,
    parameter logic [DATA_BITS-1:0] BUBBLE_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_data,
    output logic [1:0]           occupancy
);

    // Encoding equals the number of held entries so occupancy is the state register.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] main_q, main_d;
    logic [DATA_BITS-1:0] skid_q, skid_d;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic                 accept;
    logic                 take;

    assign accept = in_valid & in_ready_q;
    assign take   = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = StEmpty;
            main_d  = BUBBLE_VALUE;
            skid_d  = BUBBLE_VALUE;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d = StOne;
                        main_d  = in_data;
                    end
                end
                StOne: begin
                    if (accept && take) begin
                        main_d = in_data;
                    end else if (accept) begin
                        state_d = StTwo;
                        skid_d  = in_data;
                    end else if (take) begin
                        state_d = StEmpty;
                        main_d  = BUBBLE_VALUE;
                    end
                end
                StTwo: begin
                    if (take) begin
                        state_d = StOne;
                        main_d  = skid_q;
                        skid_d  = BUBBLE_VALUE;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean empty stage.
                    state_d = StEmpty;
                    main_d  = BUBBLE_VALUE;
                    skid_d  = BUBBLE_VALUE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StEmpty;
            main_q      <= BUBBLE_VALUE;
            skid_q      <= BUBBLE_VALUE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= (state_d != StTwo);
            out_valid_q <= (state_d != StEmpty);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign occupancy = state_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed vector table, reset/bubble corner cases,
// and randomised traffic against a queue-based reference model.
module tb_pipe_skid_reg;

    localparam logic [31:0] BUBBLE_B = 32'h0000_0020;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [1:0]  occupancy;
    logic        b_in_ready, b_out_valid;
    logic [31:0] b_out_data;
    logic [1:0]  b_occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model_q[$];

    always #5 clk = ~clk;

    pipe_skid_reg dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    pipe_skid_reg #(
        .DATA_BITS    (32),
        .BUBBLE_VALUE (BUBBLE_B)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (b_in_ready),
        .in_data   (in_data),
        .out_valid (b_out_valid),
        .out_ready (out_ready),
        .out_data  (b_out_data),
        .occupancy (b_occupancy)
    );

    typedef struct packed {
        logic        v;
        logic [31:0] d;
        logic        r;
        logic        f;
        logic        ov;
        logic [31:0] od;
        logic [1:0]  occ;
        logic        ir;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a FIFO of at most two words; readiness means fewer than two held.
    task automatic model_step(input logic v, input logic [31:0] d, input logic r,
                              input logic f);
        bit take_m, accept_m;
        take_m   = (model_q.size() > 0) && r;
        accept_m = v && (model_q.size() < 2);
        if (f) begin
            model_q.delete();
        end else begin
            if (take_m) void'(model_q.pop_front());
            if (accept_m) model_q.push_back(d);
        end
    endtask

    task automatic check_model();
        int n;
        n = model_q.size();
        chk("out_valid", {31'b0, out_valid}, {31'b0, n != 0});
        chk("out_data", out_data, (n != 0) ? model_q[0] : 32'h0);
        chk("occupancy", {30'b0, occupancy}, n);
        chk("in_ready", {31'b0, in_ready}, {31'b0, n < 2});
        chk("b_out_valid", {31'b0, b_out_valid}, {31'b0, n != 0});
        chk("b_out_data", b_out_data, (n != 0) ? model_q[0] : BUBBLE_B);
        chk("b_occupancy", {30'b0, b_occupancy}, n);
        chk("b_in_ready", {31'b0, b_in_ready}, {31'b0, n < 2});
    endtask

    task automatic cycle(input logic v, input logic [31:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        @(posedge clk);
        model_step(v, d, r, f);
        #1;
        check_model();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_out_data"}, out_data, 32'h0);
        chk({tag, "_occupancy"}, {30'b0, occupancy}, 32'd0);
        chk({tag, "_b_out_data"}, b_out_data, BUBBLE_B);
        chk({tag, "_b_out_valid"}, {31'b0, b_out_valid}, 32'd0);
    endtask

    initial begin
        //         v     d             r     f     ov    od            occ    ir
        tbl[0]  = '{1'b1, 32'h11, 1'b1, 1'b0, 1'b1, 32'h11, 2'd1, 1'b1};
        tbl[1]  = '{1'b1, 32'h22, 1'b1, 1'b0, 1'b1, 32'h22, 2'd1, 1'b1};
        tbl[2]  = '{1'b1, 32'h33, 1'b1, 1'b0, 1'b1, 32'h33, 2'd1, 1'b1};
        tbl[3]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 2'd0, 1'b1};
        tbl[4]  = '{1'b1, 32'hA1, 1'b0, 1'b0, 1'b1, 32'hA1, 2'd1, 1'b1};
        tbl[5]  = '{1'b1, 32'hA2, 1'b0, 1'b0, 1'b1, 32'hA1, 2'd2, 1'b0};
        tbl[6]  = '{1'b1, 32'hA3, 1'b0, 1'b0, 1'b1, 32'hA1, 2'd2, 1'b0};
        tbl[7]  = '{1'b1, 32'hA3, 1'b1, 1'b0, 1'b1, 32'hA2, 2'd1, 1'b1};
        tbl[8]  = '{1'b1, 32'hA3, 1'b1, 1'b0, 1'b1, 32'hA3, 2'd1, 1'b1};
        tbl[9]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 2'd0, 1'b1};
        tbl[10] = '{1'b1, 32'hB1, 1'b0, 1'b0, 1'b1, 32'hB1, 2'd1, 1'b1};
        tbl[11] = '{1'b1, 32'hB2, 1'b0, 1'b0, 1'b1, 32'hB1, 2'd2, 1'b0};
        tbl[12] = '{1'b1, 32'hB3, 1'b0, 1'b1, 1'b0, 32'h00, 2'd0, 1'b1};
        tbl[13] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 2'd0, 1'b1};
        tbl[14] = '{1'b1, 32'hC1, 1'b1, 1'b0, 1'b1, 32'hC1, 2'd1, 1'b1};
        tbl[15] = '{1'b1, 32'hC2, 1'b1, 1'b1, 1'b0, 32'h00, 2'd0, 1'b1};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst_held");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].f);
            chk($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].ov});
            chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].od);
            chk($sformatf("vec%0d_occupancy", i), {30'b0, occupancy}, {30'b0, tbl[i].occ});
            chk($sformatf("vec%0d_in_ready", i), {31'b0, in_ready}, {31'b0, tbl[i].ir});
        end

        // Fill to two entries, then reset between edges without any clock edge.
        cycle(1'b1, 32'hD1, 1'b0, 1'b0);
        cycle(1'b1, 32'hD2, 1'b0, 1'b0);
        chk("pre_rst_occupancy", {30'b0, occupancy}, 32'd2);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        model_q.delete();
        @(posedge clk);
        #1;
        check_reset_outputs("rst_mid_held");
        @(negedge clk);
        rst = 1'b0;
        // Skid must be cleared: a single word then drains to bubble.
        cycle(1'b1, 32'hE1, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            cycle(1'($urandom_range(0, 2) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 49) == 0));
        end

        // Drain so the bubble value is observed on both instances at the end.
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("drain_b_out_data", b_out_data, BUBBLE_B);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
